dmem_resp: RTL and testbench

- Data-side responder that sits on the core's data port: it receives the core's data address, byte-lane write strobes and four write-data bytes, and returns read data.
- Contains a word-organised data RAM with per-byte-lane writes.
- Contains a small memory-mapped peripheral window: GPIO output register, free-running timer with compare/interrupt, control/status, scratch register.
- Flags bus errors on writes to unmapped addresses.

---
 rtl/dmem_resp.sv | 173 +++++++++++++++++
 tb/tb_dmem_resp.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: data-side responder for the core's data port.
// Serves a word-organised RAM with byte-lane writes and a 256-byte
// peripheral window (GPIO, timer with compare/interrupt, control, status,
// scratch). A write to an unmapped address is dropped and raises a sticky
// error bit.
//
// Handshake: there is no valid/ready pair. Every cycle is a transfer:
// data_out is a combinational read of data_addr, and any nonzero
// datamem_wr commits on the next rising edge of clk (read-old semantics).
module dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [3:0]  datamem_wr,
    input  logic [7:0]  data_in0,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    input  logic [7:0]  data_in3,
    output logic [31:0] data_out,
    output logic [7:0]  gpio_out,
    output logic        timer_irq,
    output logic        bus_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

    // Register offsets inside the peripheral window (word index = addr[7:2]).
    localparam logic [5:0] OFF_GPIO    = 6'h00;
    localparam logic [5:0] OFF_MTIME   = 6'h01;
    localparam logic [5:0] OFF_MTIMECM = 6'h02;
    localparam logic [5:0] OFF_CTRL    = 6'h03;
    localparam logic [5:0] OFF_STATUS  = 6'h04;
    localparam logic [5:0] OFF_SCRATCH = 6'h05;

    // Replace the bytes of old_word selected by lanes with new_word bytes.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int n = 0; n < 4; n++) begin
            if (lanes[n]) res[8*n +: 8] = new_word[8*n +: 8];
        end
        return res;
    endfunction

    logic [31:0]   wr_word;
    logic          ram_hit;
    logic          mmio_hit;
    logic          any_wr;
    logic          unmapped_wr;
    logic [AW-1:0] word_idx;
    logic [5:0]    reg_off;

    logic [31:0] mem [DEPTH_WORDS];

    logic [7:0]  gpio_q;
    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtimecmp_q;
    logic [31:0] scratch_q;
    logic [2:0]  ctrl_q;
    logic        pend_q, pend_d;
    logic        err_q, err_d;

    logic        timer_en;
    logic        timer_ie;
    logic        timer_reload;
    logic        timer_match;

    logic        wr_gpio, wr_mtime, wr_mtimecmp, wr_ctrl, wr_status, wr_scratch;

    // Address decode and write-select strobes.
    always_comb begin
        wr_word     = {data_in3, data_in2, data_in1, data_in0};
        ram_hit     = (data_addr < RAM_BYTES);
        mmio_hit    = !ram_hit && (data_addr[31:8] == MMIO_BASE[31:8]);
        any_wr      = (datamem_wr != 4'h0);
        unmapped_wr = any_wr && !ram_hit && !mmio_hit;
        word_idx    = data_addr[AW+1:2];
        reg_off     = data_addr[7:2];

        wr_gpio     = mmio_hit && (reg_off == OFF_GPIO)    && datamem_wr[0];
        wr_mtime    = mmio_hit && (reg_off == OFF_MTIME)   && any_wr;
        wr_mtimecmp = mmio_hit && (reg_off == OFF_MTIMECM) && any_wr;
        wr_ctrl     = mmio_hit && (reg_off == OFF_CTRL)    && datamem_wr[0];
        wr_status   = mmio_hit && (reg_off == OFF_STATUS)  && datamem_wr[0];
        wr_scratch  = mmio_hit && (reg_off == OFF_SCRATCH) && any_wr;
    end

    // Data RAM: per-lane writes, deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_hit) begin
            for (int n = 0; n < 4; n++) begin
                if (datamem_wr[n]) mem[word_idx][8*n +: 8] <= wr_word[8*n +: 8];
            end
        end
    end

    // Timer next-state and sticky status bits; a hardware set beats a W1C.
    always_comb begin
        timer_en     = ctrl_q[0];
        timer_ie     = ctrl_q[1];
        timer_reload = ctrl_q[2];
        timer_match  = timer_en && (mtime_q == mtimecmp_q);

        mtime_d = mtime_q;
        if (timer_en) begin
            mtime_d = (timer_match && timer_reload) ? 32'h0 : mtime_q + 32'd1;
        end
        if (wr_mtime) begin
            mtime_d = lane_merge(mtime_q, wr_word, datamem_wr);
        end

        pend_d = pend_q;
        if (wr_status && data_in0[0]) pend_d = 1'b0;
        if (timer_match)              pend_d = 1'b1;

        err_d = err_q;
        if (wr_status && data_in0[1]) err_d = 1'b0;
        if (unmapped_wr)              err_d = 1'b1;
    end

    // Peripheral registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q     <= 8'h00;
            mtime_q    <= 32'h0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            ctrl_q     <= 3'b000;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            scratch_q  <= 32'h0;
        end else begin
            if (wr_gpio)     gpio_q     <= data_in0;
            if (wr_mtimecmp) mtimecmp_q <= lane_merge(mtimecmp_q, wr_word, datamem_wr);
            if (wr_ctrl)     ctrl_q     <= data_in0[2:0];
            if (wr_scratch)  scratch_q  <= lane_merge(scratch_q, wr_word, datamem_wr);
            mtime_q <= mtime_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Combinational read mux; unmapped space and unused offsets read zero.
    always_comb begin
        data_out = 32'h0;
        if (ram_hit) begin
            data_out = mem[word_idx];
        end else if (mmio_hit) begin
            case (reg_off)
                OFF_GPIO:    data_out = {24'h0, gpio_q};
                OFF_MTIME:   data_out = mtime_q;
                OFF_MTIMECM: data_out = mtimecmp_q;
                OFF_CTRL:    data_out = {29'h0, ctrl_q};
                OFF_STATUS:  data_out = {30'h0, err_q, pend_q};
                OFF_SCRATCH: data_out = scratch_q;
                default:     data_out = 32'h0;
            endcase
        end
    end

    // Output pins.
    always_comb begin
        gpio_out  = gpio_q;
        timer_irq = pend_q && timer_ie;
        bus_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural memory-map model.
module tb_dmem_resp;

    localparam logic [31:0] M        = 32'h8000_0000;
    localparam int          RAM_SIZE = 4096;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic [31:0] data_addr;
    logic [3:0]  datamem_wr;
    logic [7:0]  data_in0, data_in1, data_in2, data_in3;
    logic [31:0] data_out;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        bus_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .data_addr  (data_addr),
        .datamem_wr (datamem_wr),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .data_out   (data_out),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq),
        .bus_err    (bus_err)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram   [RAM_SIZE/4];
    bit   [3:0]  m_known [RAM_SIZE/4];
    logic [7:0]  m_gpio;
    logic [31:0] m_mtime, m_cmp, m_scr;
    logic [2:0]  m_ctrl;
    logic        m_pend, m_err;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] l);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (l[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:8] == M[31:8];
    endfunction

    task automatic model_reset();
        m_gpio  = 8'h00;
        m_mtime = 32'h0;
        m_cmp   = 32'hFFFF_FFFF;
        m_ctrl  = 3'b000;
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_scr   = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] a, w, nt;
        logic [3:0]  wr;
        logic        hit, np, ne;
        int          idx;
        a   = data_addr;
        wr  = datamem_wr;
        w   = {data_in3, data_in2, data_in1, data_in0};
        hit = m_ctrl[0] && (m_mtime == m_cmp);
        nt  = m_ctrl[0] ? ((hit && m_ctrl[2]) ? 32'h0 : m_mtime + 32'd1) : m_mtime;
        np  = m_pend || hit;
        ne  = m_err;
        if (wr != 4'h0) begin
            if (a < RAM_SIZE) begin
                idx = int'(a >> 2);
                m_ram[idx] = merge(m_ram[idx], w, wr);
                m_known[idx] = m_known[idx] | wr;
            end else if (is_mmio(a)) begin
                case (a[7:0] & 8'hFC)
                    8'h00: if (wr[0]) m_gpio = w[7:0];
                    8'h04: nt = merge(m_mtime, w, wr);
                    8'h08: m_cmp = merge(m_cmp, w, wr);
                    8'h0C: if (wr[0]) m_ctrl = w[2:0];
                    8'h10: if (wr[0]) begin
                        if (w[0] && !hit) np = 1'b0;
                        if (w[1]) ne = 1'b0;
                    end
                    8'h14: m_scr = merge(m_scr, w, wr);
                    default: ;
                endcase
            end else begin
                ne = 1'b1;
            end
        end
        m_mtime = nt;
        m_pend  = np;
        m_err   = ne;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < RAM_SIZE) return m_ram[int'(a >> 2)];
        if (!is_mmio(a)) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h00:   return {24'h0, m_gpio};
            8'h04:   return m_mtime;
            8'h08:   return m_cmp;
            8'h0C:   return {29'h0, m_ctrl};
            8'h10:   return {30'h0, m_err, m_pend};
            8'h14:   return m_scr;
            default: return 32'h0;
        endcase
    endfunction

    // Lanes of never-written RAM are undefined, so they are excluded.
    function automatic logic [31:0] read_mask(input logic [31:0] a);
        logic [31:0] mk;
        bit   [3:0]  kn;
        if (a >= RAM_SIZE) return 32'hFFFF_FFFF;
        kn = m_known[int'(a >> 2)];
        for (int k = 0; k < 4; k++) mk[8*k +: 8] = kn[k] ? 8'hFF : 8'h00;
        return mk;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare process: outputs are checked mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            logic [31:0] mk;
            mk = read_mask(data_addr);
            check("data_out", data_out & mk, model_read(data_addr) & mk);
            check("gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio});
            check("timer_irq", {31'h0, timer_irq}, {31'h0, m_pend & m_ctrl[1]});
            check("bus_err", {31'h0, bus_err}, {31'h0, m_err});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        data_addr  = a;
        datamem_wr = w;
        {data_in3, data_in2, data_in1, data_in0} = d;
        @(posedge clk);
        #1;
        datamem_wr = 4'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        data_addr  = a;
        datamem_wr = 4'h0;
        #1;
        check(name, data_out, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          seq_exp [6];
        logic [31:0] a, d;
        logic [3:0]  w;
        int          kind;

        seq_exp = '{1, 2, 3, 0, 1, 2};
        rst        = 1'b1;
        data_addr  = 32'h0;
        datamem_wr = 4'h0;
        {data_in3, data_in2, data_in1, data_in0} = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check("rst_gpio", {24'h0, gpio_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        check("rst_err", {31'h0, bus_err}, 32'h0);
        peek("rst_mtimecmp", M + 32'h08, 32'hFFFF_FFFF);
        peek("rst_ctrl", M + 32'h0C, 32'h0);

        // RAM byte lanes and read-during-write
        cyc(32'h10, 4'hF, 32'hDDCC_BBAA);
        data_addr = 32'h10;
        datamem_wr = 4'b0100;
        {data_in3, data_in2, data_in1, data_in0} = 32'h0055_0000;
        #1;
        check("ram_rdw_old", data_out, 32'hDDCC_BBAA);
        tick();
        datamem_wr = 4'h0;
        peek("ram_lane2", 32'h10, 32'hDD55_BBAA);

        // GPIO lane 0 only
        cyc(M, 4'h1, 32'h0000_00A5);
        check("gpio_set", {24'h0, gpio_out}, 32'hA5);
        cyc(M, 4'h2, 32'h0000_5A00);
        check("gpio_lane1", {24'h0, gpio_out}, 32'hA5);
        peek("gpio_read", M, 32'h0000_00A5);

        // Timer match with interrupt enabled
        cyc(M + 32'h08, 4'hF, 32'd5);
        cyc(M + 32'h04, 4'hF, 32'd0);
        cyc(M + 32'h0C, 4'h1, 32'h3);
        for (int k = 1; k <= 6; k++) begin
            tick();
            peek("mtime_count", M + 32'h04, 32'(k));
            if (k == 5) check("irq_before", {31'h0, timer_irq}, 32'h0);
        end
        check("irq_match", {31'h0, timer_irq}, 32'h1);
        tick();
        peek("mtime_after", M + 32'h04, 32'd7);
        cyc(M + 32'h10, 4'h1, 32'h1);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0);

        // Autoreload
        cyc(M + 32'h0C, 4'h1, 32'h0);
        cyc(M + 32'h04, 4'hF, 32'd0);
        cyc(M + 32'h08, 4'hF, 32'd3);
        cyc(M + 32'h0C, 4'h1, 32'h5);
        peek("reload_start", M + 32'h04, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            peek("reload_seq", M + 32'h04, 32'(seq_exp[k]));
        end
        cyc(M + 32'h0C, 4'h1, 32'h0);

        // Wrap
        cyc(M + 32'h04, 4'hF, 32'hFFFF_FFFE);
        cyc(M + 32'h0C, 4'h1, 32'h1);
        peek("wrap0", M + 32'h04, 32'hFFFF_FFFE);
        tick();
        peek("wrap1", M + 32'h04, 32'hFFFF_FFFF);
        tick();
        peek("wrap2", M + 32'h04, 32'h0);
        cyc(M + 32'h0C, 4'h1, 32'h0);
        cyc(M + 32'h10, 4'h1, 32'h1);

        // Bus error
        cyc(32'h4000_0000, 4'hF, 32'h1234_5678);
        check("berr_set", {31'h0, bus_err}, 32'h1);
        peek("berr_rd_zero", 32'h4000_0000, 32'h0);
        peek("berr_ram_kept", 32'h10, 32'hDD55_BBAA);
        peek("berr_scratch", M + 32'h14, 32'h0);
        cyc(M + 32'h10, 4'h1, 32'h2);
        check("berr_w1c", {31'h0, bus_err}, 32'h0);
        peek("berr_rd_again", 32'h4000_0000, 32'h0);
        tick();
        check("berr_read_quiet", {31'h0, bus_err}, 32'h0);

        // Asynchronous reset mid-count
        cyc(M, 4'h1, 32'h3C);
        cyc(M + 32'h08, 4'hF, 32'd2);
        cyc(M + 32'h04, 4'hF, 32'd0);
        cyc(M + 32'h0C, 4'h1, 32'h3);
        tick();
        tick();
        tick();
        check("pre_rst_irq", {31'h0, timer_irq}, 32'h1);
        data_addr = M + 32'h04;
        #2;
        rst = 1'b1;
        #1;
        check("arst_gpio", {24'h0, gpio_out}, 32'h0);
        check("arst_irq", {31'h0, timer_irq}, 32'h0);
        check("arst_mtime", data_out, 32'h0);
        peek("arst_status", M + 32'h10, 32'h0);
        peek("arst_ram", 32'h10, 32'hDD55_BBAA);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        peek("arst_stopped", M + 32'h04, 32'h0);

        // Randomized phase: fill a RAM window first so reads are defined
        for (int k = 0; k < 16; k++) cyc(32'(k * 4), 4'hF, $urandom);
        for (int n = 0; n < 3000; n++) begin
            kind = $urandom_range(0, 9);
            w = 4'($urandom_range(0, 15));
            d = $urandom;
            if (kind <= 3) begin
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            end else if (kind <= 7) begin
                a = M + 32'($urandom_range(0, 7) * 4);
                if (a[7:0] == 8'h04 || a[7:0] == 8'h08) d = 32'($urandom_range(0, 24));
                if (a[7:0] == 8'h10 && $urandom_range(0, 3) != 0) w = 4'h0;
            end else if (kind == 8) begin
                a = 32'h4000_0000 + 32'($urandom_range(0, 65535));
            end else begin
                a = ($urandom_range(0, 1) == 0) ? 32'(RAM_SIZE) : M + 32'h100;
            end
            cyc(a, w, d);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
